apb_bridge_node: RTL and testbench
==================================

# apb_bridge_node

Registered APB 1-to-N bridge. It is the parametrised successor to the fixed 9-slave SoC peripheral bus. A single APB master port is decoded against a parameter-supplied address map and forwarded to one of `NB_SLAVES` slave ports through a registered access state machine. Unmapped addresses get an immediate error response. A per-transfer wait-state watchdog aborts hung slaves with `PSLVERR`. The block sits between the AXI-to-APB bridge and the SoC peripherals (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC control, Kuznechik, debug).

## Interface

**Parameters**
- `NB_SLAVES`, default 9: number of slave ports; must be at least 1.
- `APB_ADDR_WIDTH`, default 32: address width.
- `APB_DATA_WIDTH`, default 32: data width.
- `TIMEOUT`, default 16: maximum slave wait cycles in ACCESS. 0 disables the watchdog.
- `START_ADDR`, default `{NB_SLAVES{32'h0}}`: packed `[NB_SLAVES*APB_ADDR_WIDTH]`. Slice *i* is the inclusive start address of slave *i*.
- `END_ADDR`, default `{NB_SLAVES{32'h0}}`: packed, same layout. Slice *i* is the inclusive end address of slave *i*.

**Ports**
- `HCLK` (in, 1): clock. All state changes on its rising edge.
- `HRESETn` (in, 1): asynchronous, active-low reset.
- `m_paddr`, `m_pwdata`, `m_pwrite`, `m_psel`, `m_penable` (in; ADDR/DATA/1/1/1): master request.
- `m_prdata` (out, DATA): read data to the master.
- `m_pready` (out, 1): transfer-complete strobe to the master.
- `m_pslverr` (out, 1): error flag to the master.
- `s_paddr` (out, ADDR): shared slave address.
- `s_pwdata` (out, DATA): shared slave write data.
- `s_pwrite` (out, 1): shared slave write strobe.
- `s_penable` (out, 1): shared slave enable.
- `s_psel` (out, NB_SLAVES): one-hot slave select.
- `s_prdata` (in, NB_SLAVES*DATA): packed slave read data, slice *i* from slave *i*.
- `s_pready`, `s_pslverr` (in, NB_SLAVES each): per-slave ready and error.
- `timeout_o` (out, 1): one-cycle pulse when a watchdog abort occurs.
- `unmapped_o` (out, 1): one-cycle pulse when an unmapped access is rejected.

## Operation

**Address decode.** Slave *i* is hit when `START_ADDR[i] <= m_paddr <= END_ADDR[i]`, unsigned. If several ranges match, the lowest index wins. If none match, the access is unmapped.

**State machine.** States are IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - On `m_psel=1 && m_penable=0`: latch addr, wdata, write and the decoded index into the slave output registers.
  - If mapped, go to SETUP. If unmapped, go to RESP with `m_pslverr=1`, `m_prdata=0`, and pulse `unmapped_o`.
- **SETUP**: `s_psel[idx]=1`, `s_penable=0`. Go to ACCESS next cycle.
- **ACCESS**
  - Drive `s_psel[idx]=1`, `s_penable=1`.
  - When `s_pready[idx]=1`: capture `s_prdata[idx]` and `s_pslverr[idx]`, drop `s_psel`/`s_penable`, go to RESP.
  - Otherwise increment the wait counter. Counter width is `$clog2(TIMEOUT+1)`, cleared on entry to SETUP.
  - When the counter equals `TIMEOUT` (and `TIMEOUT≠0`) with `s_pready` still low: drop `s_psel`/`s_penable`, go to RESP with `m_pslverr=1` and `m_prdata=0`, and pulse `timeout_o`.
- **RESP**
  - If `m_psel && m_penable`: assert `m_pready=1` for one cycle with the captured `m_prdata`/`m_pslverr`, then go to IDLE.
  - If `m_psel=0` (master protocol violation): go to IDLE without asserting `m_pready`.
- **Signal lifetimes.**
  - `m_pready` is 0 in every state except RESP.
  - `m_prdata`/`m_pslverr` are valid only while `m_pready=1` and are 0 otherwise.
  - `s_paddr`/`s_pwdata`/`s_pwrite` hold their last value between transfers.
- **Master drop mid-transfer.** If `m_psel` drops during SETUP or ACCESS, the slave transfer still completes normally (APB slaves cannot be aborted). The response is discarded in RESP.

## Timing

- **Reset.** All outputs are 0 and the state is IDLE, immediately on `HRESETn` low, independent of `HCLK`. An in-flight slave transfer is abandoned: `s_psel` drops asynchronously.
- **Mapped latency.** Master setup is sampled at edge T0. Slave SETUP occupies T0–T1 and ACCESS starts at T1. With a zero-wait slave, `m_pready` is high during the cycle after T2. The master therefore sees 2 wait cycles plus one wait per slave wait state.
- **Unmapped latency.** `m_pready=1` with `m_pslverr=1` in the cycle after T0, i.e. zero master wait states.
- **Timeout latency.** Abort happens `TIMEOUT` ACCESS cycles after ACCESS entry. `m_pready` follows in the next cycle.
- **Back-to-back transfers.** A new master setup is accepted in the IDLE cycle immediately after RESP. Minimum spacing is one IDLE cycle between transfers.
- **Reset release.** At most one `s_psel` bit is high at any time. `s_penable` is high only in ACCESS.

## Test plan

- **Zero-wait read.** Map: slave 0 = 0x1A10_0000–0x1A10_0FFF, slave 1 = 0x1A10_1000–0x1A10_1FFF. Read 0x1A10_1004 with slave 1 `prdata=0xDEADBEEF`, pready=1. Required: `s_psel=2'b10` for exactly 2 cycles; `m_pready` on the 3rd cycle after setup; `m_prdata=0xDEADBEEF`, `m_pslverr=0`.
- **Write with waits.** Write 0x1234_5678 to 0x1A10_0010 while slave 0 holds pready low for 3 ACCESS cycles. Required: slave sees `pwdata=0x12345678`, `pwrite=1`; `m_pready` arrives 3 cycles later than in the zero-wait case; `m_pslverr=0`.
- **Unmapped read.** Read 0x1A20_0000. Required: no `s_psel` bit ever goes high; `m_pready=1`, `m_pslverr=1`, `m_prdata=0` in the cycle after setup; `unmapped_o` pulses once.
- **Timeout.** With `TIMEOUT=4`, slave 0 never asserts pready. Required: `s_psel` drops after 4 ACCESS cycles; `timeout_o` pulses; next cycle `m_pready=1`, `m_pslverr=1`, `m_prdata=0`. Repeat with `TIMEOUT=0`: no abort after 100 cycles.
- **Overlap priority.** Slave 2 and slave 5 both cover 0x1A10_2000. Access that address. Required: only `s_psel[2]` asserts.
- **Reset mid-access.** Assert `HRESETn` low during ACCESS. Required: `s_psel=0`, `s_penable=0`, `m_pready=0` before the next `HCLK` edge. After release, a fresh read completes normally.

Source files
------------

// File: rtl/apb_bridge_node.sv
// Registered APB 1-to-N bridge: decodes one master port onto NB_SLAVES slave
// ports, rejects unmapped accesses and aborts slaves that stall too long.
module apb_bridge_node #(
  parameter int NB_SLAVES      = 9,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 16,
  parameter logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] END_ADDR   = '0
) (
  input  logic                                HCLK,
  input  logic                                HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0]           m_paddr,
  input  logic [APB_DATA_WIDTH-1:0]           m_pwdata,
  input  logic                                m_pwrite,
  input  logic                                m_psel,
  input  logic                                m_penable,
  output logic [APB_DATA_WIDTH-1:0]           m_prdata,
  output logic                                m_pready,
  output logic                                m_pslverr,
  output logic [APB_ADDR_WIDTH-1:0]           s_paddr,
  output logic [APB_DATA_WIDTH-1:0]           s_pwdata,
  output logic                                s_pwrite,
  output logic                                s_penable,
  output logic [NB_SLAVES-1:0]                s_psel,
  input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] s_prdata,
  input  logic [NB_SLAVES-1:0]                s_pready,
  input  logic [NB_SLAVES-1:0]                s_pslverr,
  output logic                                timeout_o,
  output logic                                unmapped_o
);

  localparam int IW = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state, state_n;
  logic [IW-1:0]       idx_q, dec_idx;
  logic [CW-1:0]       cnt_q, cnt_nxt;
  logic [NB_SLAVES-1:0] hit;
  logic                dec_hit;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                err_q, tmo_q, unm_q;
  logic                latch, capture, abort, reject, cnt_inc;

  for (genvar i = 0; i < NB_SLAVES; i++) begin : g_dec
    assign hit[i] = (m_paddr >= START_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
                    (m_paddr <= END_ADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]);
  end

  // Scan from the top so the lowest matching index overrides the rest.
  always_comb begin
    dec_idx = '0;
    dec_hit = 1'b0;
    for (int i = NB_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_idx = IW'(i);
        dec_hit = 1'b1;
      end
    end
  end

  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    reject  = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      IDLE: begin
        if (m_psel && !m_penable) begin
          latch = 1'b1;
          if (dec_hit) begin
            state_n = SETUP;
          end else begin
            reject  = 1'b1;
            state_n = RESP;
          end
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (s_pready[idx_q]) begin
          capture = 1'b1;
          state_n = RESP;
        end else if ((TIMEOUT != 0) && (cnt_nxt == CW'(TIMEOUT))) begin
          abort   = 1'b1;
          state_n = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        // A master that dropped psel forfeits the response.
        if (!m_psel || m_penable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      s_paddr  <= '0;
      s_pwdata <= '0;
      s_pwrite <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      unm_q    <= 1'b0;
    end else begin
      state <= state_n;
      tmo_q <= abort;
      unm_q <= reject;
      if (latch) begin
        s_paddr  <= m_paddr;
        s_pwdata <= m_pwdata;
        s_pwrite <= m_pwrite;
        idx_q    <= dec_idx;
        cnt_q    <= '0;
        rdata_q  <= '0;
        err_q    <= !dec_hit;
      end else if (cnt_inc) begin
        cnt_q <= cnt_nxt;
      end
      if (capture) begin
        rdata_q <= s_prdata[idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        err_q   <= s_pslverr[idx_q];
      end else if (abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    s_psel = '0;
    if (state == SETUP || state == ACCESS) s_psel[idx_q] = 1'b1;
  end

  assign s_penable  = (state == ACCESS);
  assign m_pready   = (state == RESP) && m_psel && m_penable;
  assign m_prdata   = m_pready ? rdata_q : '0;
  assign m_pslverr  = m_pready && err_q;
  assign timeout_o  = tmo_q;
  assign unmapped_o = unm_q;

endmodule

// File: tb/tb_apb_bridge_node.sv
// Randomised scoreboard bench for apb_bridge_node against a transaction-level
// model of decode, wait states and the watchdog.
module tb_apb_bridge_node;
  localparam int NS = 6, AW = 32, DW = 32, TO = 4;
  localparam logic [NS*AW-1:0] ST = {32'h1A10_2000, 32'h1A10_4000, 32'h1A10_3000,
                                     32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000};
  localparam logic [NS*AW-1:0] EN = {32'h1A10_5FFF, 32'h1A10_4FFF, 32'h1A10_3FFF,
                                     32'h1A10_2FFF, 32'h1A10_1FFF, 32'h1A10_0FFF};

  logic [31:0] map_lo [NS] = '{32'h1A10_0000, 32'h1A10_1000, 32'h1A10_2000,
                               32'h1A10_3000, 32'h1A10_4000, 32'h1A10_2000};
  logic [31:0] map_hi [NS] = '{32'h1A10_0FFF, 32'h1A10_1FFF, 32'h1A10_2FFF,
                               32'h1A10_3FFF, 32'h1A10_4FFF, 32'h1A10_5FFF};

  logic HCLK, HRESETn;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_prdata;
  logic m_pwrite, m_psel, m_penable, m_pready, m_pslverr;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata;
  logic s_pwrite, s_penable, timeout_o, unmapped_o;
  logic [NS-1:0] s_psel, s_pready, s_pslverr;
  logic [NS*DW-1:0] s_prdata;

  // second instance with the watchdog disabled
  logic [AW-1:0] z_paddr, z_s_paddr;
  logic [DW-1:0] z_pwdata, z_prdata, z_s_pwdata, z_s_prdata;
  logic z_pwrite, z_psel, z_penable, z_pready, z_pslverr;
  logic z_s_pwrite, z_s_penable, z_s_psel, z_s_pready, z_s_pslverr, z_timeout, z_unmapped;

  apb_bridge_node #(.NB_SLAVES(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
                    .TIMEOUT(TO), .START_ADDR(ST), .END_ADDR(EN)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite), .m_psel(m_psel),
    .m_penable(m_penable), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite), .s_penable(s_penable),
    .s_psel(s_psel), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .timeout_o(timeout_o), .unmapped_o(unmapped_o));

  apb_bridge_node #(.NB_SLAVES(1), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
                    .TIMEOUT(0), .START_ADDR(32'h0), .END_ADDR(32'hFFFF_FFFF)) dut_z (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_paddr(z_paddr), .m_pwdata(z_pwdata), .m_pwrite(z_pwrite), .m_psel(z_psel),
    .m_penable(z_penable), .m_prdata(z_prdata), .m_pready(z_pready), .m_pslverr(z_pslverr),
    .s_paddr(z_s_paddr), .s_pwdata(z_s_pwdata), .s_pwrite(z_s_pwrite), .s_penable(z_s_penable),
    .s_psel(z_s_psel), .s_prdata(z_s_prdata), .s_pready(z_s_pready), .s_pslverr(z_s_pslverr),
    .timeout_o(z_timeout), .unmapped_o(z_unmapped));

  typedef struct {
    logic [31:0] rdata; logic err; int mwaits; int pselcyc; int idx;
    logic [31:0] addr; logic [31:0] wdata; logic wr; logic tmo; logic unm;
  } exp_t;

  exp_t exq[$];
  exp_t mon_e;
  int total = 0, bad = 0;
  int mw = 0, pc = 0, acc_cnt, cur_waits = 0;
  bit mon_en = 0;
  logic [DW-1:0] cur_rd [NS];
  logic [NS-1:0] cur_err = '0;

  initial begin
    HCLK = 0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Slave side: the selected slave raises pready after cur_waits ACCESS cycles.
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) acc_cnt <= 0;
    else if (s_penable && s_pready == '0) acc_cnt <= acc_cnt + 1;
    else if (!s_penable) acc_cnt <= 0;

  always_comb begin
    s_pready = '0;
    if (s_penable && acc_cnt >= cur_waits) s_pready = s_psel;
    s_prdata = '0;
    for (int i = 0; i < NS; i++) s_prdata[i*DW +: DW] = cur_rd[i];
    s_pslverr = cur_err;
  end

  function automatic exp_t model(input logic [31:0] a, input logic wr,
                                 input logic [31:0] wd, input int w);
    exp_t e;
    e.idx = -1;
    for (int i = NS - 1; i >= 0; i--)
      if (a >= map_lo[i] && a <= map_hi[i]) e.idx = i;
    e.addr = a; e.wr = wr; e.wdata = wd; e.tmo = 0; e.unm = 0;
    if (e.idx < 0) begin
      e.rdata = 0; e.err = 1; e.unm = 1; e.mwaits = 0; e.pselcyc = 0;
    end else if (w + 1 > TO) begin
      e.rdata = 0; e.err = 1; e.tmo = 1; e.mwaits = 1 + TO; e.pselcyc = 1 + TO;
    end else begin
      e.rdata = cur_rd[e.idx]; e.err = cur_err[e.idx];
      e.mwaits = 2 + w; e.pselcyc = 2 + w;
    end
    return e;
  endfunction

  // Monitor: per-cycle slave-side checks, pops the scoreboard on m_pready.
  always @(negedge HCLK) begin
    if (mon_en && HRESETn) begin
      if (s_psel != '0) begin
        pc++;
        if (exq.size() > 0) begin
          chk("s_psel", 32'(s_psel), 32'(1) << exq[0].idx);
          chk("s_paddr", s_paddr, exq[0].addr);
          chk("s_pwrite", 32'(s_pwrite), 32'(exq[0].wr));
          if (exq[0].wr) chk("s_pwdata", s_pwdata, exq[0].wdata);
        end else chk("s_psel_idle", 32'(s_psel), 0);
      end
      if (s_penable) chk("penable_without_psel", 32'(s_psel != '0), 1);
      if (m_psel && m_penable && !m_pready) mw++;
      if (m_pready) begin
        if (exq.size() == 0) chk("unexpected_pready", 1, 0);
        else begin
          mon_e = exq.pop_front();
          chk("m_prdata", m_prdata, mon_e.rdata);
          chk("m_pslverr", 32'(m_pslverr), 32'(mon_e.err));
          chk("master_waits", mw, mon_e.mwaits);
          chk("psel_cycles", pc, mon_e.pselcyc);
          chk("timeout_o", 32'(timeout_o), 32'(mon_e.tmo));
          chk("unmapped_o", 32'(unmapped_o), 32'(mon_e.unm));
        end
        mw = 0;
        pc = 0;
      end else begin
        chk("idle_prdata", m_prdata, 0);
        chk("idle_pslverr", 32'(m_pslverr), 0);
        chk("idle_timeout_o", 32'(timeout_o), 0);
        chk("idle_unmapped_o", 32'(unmapped_o), 0);
      end
    end
  end

  task automatic rand_slaves();
    for (int i = 0; i < NS; i++) cur_rd[i] = $urandom;
    cur_err = NS'($urandom);
  endtask

  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd, input int w);
    int n;
    cur_waits = w;
    exq.push_back(model(a, wr, wd, w));
    m_paddr = a; m_pwrite = wr; m_pwdata = wd; m_psel = 1; m_penable = 0;
    @(posedge HCLK); #1 m_penable = 1;
    n = 0;
    while (n < 60) begin
      @(negedge HCLK);
      if (m_pready) break;
      n++;
    end
    if (n >= 60) begin
      chk("xfer_no_pready", 0, 1);
      exq.delete();
    end
    @(posedge HCLK); #1 m_psel = 0; m_penable = 0;
  endtask

  initial begin
    int viol;
    logic [31:0] a;
    HRESETn = 0;
    m_paddr = 0; m_pwdata = 0; m_pwrite = 0; m_psel = 0; m_penable = 0;
    z_paddr = 0; z_pwdata = 0; z_pwrite = 0; z_psel = 0; z_penable = 0;
    z_s_prdata = 32'h5555_AAAA; z_s_pready = 0; z_s_pslverr = 0;
    rand_slaves();
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_m_pready", 32'(m_pready), 0);
    chk("rst_s_psel", 32'(s_psel), 0);
    chk("rst_s_penable", 32'(s_penable), 0);
    chk("rst_s_paddr", s_paddr, 0);
    chk("rst_timeout_o", 32'(timeout_o), 0);
    chk("rst_unmapped_o", 32'(unmapped_o), 0);
    HRESETn = 1;
    @(posedge HCLK); #1 mon_en = 1;

    // watchdog disabled: a never-ready slave must stay selected
    z_paddr = 32'h1A10_0000; z_psel = 1;
    @(posedge HCLK); #1 z_penable = 1;
    viol = 0;
    repeat (100) begin
      @(negedge HCLK);
      if (z_pready || z_timeout || !z_s_psel) viol++;
    end
    chk("to0_no_abort", viol, 0);
    chk("to0_penable_held", 32'(z_s_penable), 1);

    rand_slaves(); cur_rd[1] = 32'hDEADBEEF; cur_err = '0;
    xfer(32'h1A10_1004, 0, 32'h0, 0);
    cur_err = '0;
    xfer(32'h1A10_0010, 1, 32'h1234_5678, 3);
    xfer(32'h1A20_0000, 0, 32'h0, 0);
    xfer(32'h1A10_0020, 0, 32'h0, 50);
    rand_slaves();
    xfer(32'h1A10_2000, 0, 32'h0, 1);
    xfer(32'h1A10_5000, 1, 32'hCAFE_0001, 0);
    xfer(32'h1A10_0FFF, 0, 32'h0, 0);
    xfer(32'h1A10_1000, 0, 32'h0, 0);
    xfer(32'h1A0F_FFFF, 0, 32'h0, 0);
    xfer(32'h1A10_6000, 1, 32'h0, 0);
    xfer(32'h1A10_5FFF, 0, 32'h0, 4);
    xfer(32'h1A10_3000, 0, 32'h0, 3);

    for (int k = 0; k < 200; k++) begin
      rand_slaves();
      if ($urandom_range(0, 3) != 0) a = 32'h1A10_0000 + $urandom_range(0, 32'h6FFF);
      else a = $urandom;
      xfer(a, 1'($urandom), $urandom, $urandom_range(0, 6));
    end

    // asynchronous reset while a slave is stalled in ACCESS
    mon_en = 0;
    cur_waits = 20;
    m_paddr = 32'h1A10_0100; m_pwrite = 0; m_psel = 1; m_penable = 0;
    @(posedge HCLK); #1 m_penable = 1;
    @(posedge HCLK);
    @(posedge HCLK);
    #2 HRESETn = 0;
    #1;
    chk("midrst_s_psel", 32'(s_psel), 0);
    chk("midrst_s_penable", 32'(s_penable), 0);
    chk("midrst_m_pready", 32'(m_pready), 0);
    m_psel = 0; m_penable = 0;
    @(posedge HCLK); #1 HRESETn = 1;
    exq.delete();
    mw = 0; pc = 0;
    @(posedge HCLK); #1 mon_en = 1;
    rand_slaves();
    xfer(32'h1A10_4008, 0, 32'h0, 1);

    repeat (3) @(posedge HCLK);
    chk("scoreboard_empty", exq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
